// File: rtl/pwm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_pkg : register map, bit indices and encodings for pwm_multi        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package pwm_pkg;

  localparam logic [7:0] ADDR_GCTRL   = 8'h00;
  localparam logic [7:0] ADDR_PERIOD  = 8'h04;
  localparam logic [7:0] ADDR_STATUS  = 8'h08;
  localparam logic [7:0] ADDR_CH_BASE = 8'h10;

  localparam int GCTRL_ENABLE_BIT = 0;
  localparam int GCTRL_MODE_BIT   = 1;
  localparam int GCTRL_IRQ_EN_BIT = 2;
  localparam int GCTRL_W          = 3;

  localparam int STATUS_ERROR_BIT = 0;
  localparam int STATUS_DONE_BIT  = 1;

  localparam int CH_POL_BIT = 31;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Word index of a channel register relative to ADDR_CH_BASE
  function automatic logic [5:0] ch_word_index(input logic [7:0] a);
    return a[7:2] - ADDR_CH_BASE[7:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_channel : staged/active duty and polarity, compare and output reg  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wduty_i,
  input  logic             wpol_i,
  input  logic             reload_i,
  input  logic             idle_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] period_act_i,
  input  logic [CNT_W-1:0] period_stg_i,
  output logic [CNT_W-1:0] duty_stg_o,
  output logic             pol_stg_o,
  output logic             err_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] duty_stg_q;
  logic [CNT_W-1:0] duty_act_q;
  logic             pol_stg_q;
  logic             pol_act_q;
  logic             pwm_q;
  logic             pwm_d;
  logic             raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_stg_q <= '0;
      duty_act_q <= '0;
      pol_stg_q  <= 1'b0;
      pol_act_q  <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      if (we_i) begin
        duty_stg_q <= wduty_i;
        pol_stg_q  <= wpol_i;
      end
      // Reload samples the pre-write staged value on a coincident write
      if (reload_i) begin
        duty_act_q <= duty_stg_q;
        pol_act_q  <= pol_stg_q;
      end
      pwm_q <= pwm_d;
    end
  end

  always_comb begin
    raw   = 1'b0;
    pwm_d = 1'b0;
    if (duty_act_q >= period_act_i) begin
      raw = 1'b1;
    end else begin
      raw = (cnt_i < duty_act_q);
    end
    pwm_d = idle_i ? pol_act_q : (raw ^ pol_act_q);
  end

  assign duty_stg_o = duty_stg_q;
  assign pol_stg_o  = pol_stg_q;
  assign err_o      = (duty_stg_q > period_stg_i);
  assign pwm_o      = pwm_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_multi : N-channel PWM with shared counter, shadow registers, irq   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      addr,
  input  logic [31:0]     wdata,
  input  logic            wen,
  input  logic            ren,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] pwm_out,
  output logic            irq
);

  logic [GCTRL_W-1:0] gctrl_q;
  logic [CNT_W-1:0]   period_stg_q;
  logic [CNT_W-1:0]   period_act_q;
  mode_e              mode_act_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               done_q, done_d;
  logic               irq_q;
  logic [31:0]        rdata_q, rdata_d;

  logic             enable;
  logic             period_zero;
  logic [CNT_W-1:0] pmax;
  logic             boundary;
  logic             reload;
  logic             idle;
  logic             error_flag;

  logic [5:0]       ch_idx;
  logic             ch_sel;
  logic             we_gctrl, we_period, we_status;
  logic [N_CH-1:0]  ch_we;

  logic [CNT_W-1:0] duty_stg [N_CH];
  logic [N_CH-1:0]  pol_stg;
  logic [N_CH-1:0]  ch_err;
  logic [N_CH-1:0]  ch_pwm;

  logic unused_wdata;
  assign unused_wdata = ^wdata[30:CNT_W];

  // Bus decode
  always_comb begin
    ch_idx    = ch_word_index(addr);
    ch_sel    = (addr[1:0] == 2'b00) && (addr >= ADDR_CH_BASE) && (ch_idx < 6'(N_CH));
    we_gctrl  = wen && (addr == ADDR_GCTRL);
    we_period = wen && (addr == ADDR_PERIOD);
    we_status = wen && (addr == ADDR_STATUS);
    ch_we     = '0;
    for (int n = 0; n < N_CH; n++) begin
      if (wen && ch_sel && (ch_idx == 6'(n))) begin
        ch_we[n] = 1'b1;
      end
    end
  end

  assign enable      = gctrl_q[GCTRL_ENABLE_BIT];
  assign period_zero = (period_act_q == '0);
  assign pmax        = period_act_q - CNT_W'(1);
  assign idle        = !enable || period_zero;
  assign error_flag  = |ch_err;

  always_comb begin
    boundary = 1'b0;
    if (enable && !period_zero) begin
      if (mode_act_q == MODE_EDGE) begin
        boundary = (cnt_q == pmax);
      end else begin
        boundary = (dir_q == DIR_DOWN) && (cnt_q == '0);
      end
    end
  end

  // A zero active period also reloads, so a new period can escape the idle state
  assign reload = idle || boundary;

  // Counter and direction
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (idle || boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_act_q == MODE_EDGE) begin
      cnt_d = cnt_q + CNT_W'(1);
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == pmax) begin
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Sticky period_done: a boundary set wins over a coincident clear
  always_comb begin
    done_d = done_q;
    if (we_status && wdata[STATUS_DONE_BIT]) begin
      done_d = 1'b0;
    end
    if (boundary) begin
      done_d = 1'b1;
    end
  end

  // Read mux samples pre-write state
  always_comb begin
    rdata_d = rdata_q;
    if (ren) begin
      rdata_d = '0;
      case (addr)
        ADDR_GCTRL:  rdata_d[GCTRL_W-1:0] = gctrl_q;
        ADDR_PERIOD: rdata_d[CNT_W-1:0]   = period_stg_q;
        ADDR_STATUS: begin
          rdata_d[STATUS_ERROR_BIT] = error_flag;
          rdata_d[STATUS_DONE_BIT]  = done_q;
        end
        default: begin
          for (int n = 0; n < N_CH; n++) begin
            if (ch_sel && (ch_idx == 6'(n))) begin
              rdata_d[CNT_W-1:0] = duty_stg[n];
              rdata_d[CH_POL_BIT] = pol_stg[n];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gctrl_q      <= '0;
      period_stg_q <= '0;
      period_act_q <= '0;
      mode_act_q   <= MODE_EDGE;
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (we_gctrl) begin
        gctrl_q <= wdata[GCTRL_W-1:0];
      end
      if (we_period) begin
        period_stg_q <= wdata[CNT_W-1:0];
      end
      if (reload) begin
        period_act_q <= period_stg_q;
        mode_act_q   <= mode_e'(gctrl_q[GCTRL_MODE_BIT]);
      end
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      irq_q   <= gctrl_q[GCTRL_IRQ_EN_BIT] & done_q;
      rdata_q <= rdata_d;
    end
  end

  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .we_i         (ch_we[n]),
      .wduty_i      (wdata[CNT_W-1:0]),
      .wpol_i       (wdata[CH_POL_BIT]),
      .reload_i     (reload),
      .idle_i       (idle),
      .cnt_i        (cnt_q),
      .period_act_i (period_act_q),
      .period_stg_i (period_stg_q),
      .duty_stg_o   (duty_stg[n]),
      .pol_stg_o    (pol_stg[n]),
      .err_o        (ch_err[n]),
      .pwm_o        (ch_pwm[n])
    );
  end

  assign rdata   = rdata_q;
  assign pwm_out = ch_pwm;
  assign irq     = irq_q;

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, bus-programmable PWM generator. It is the parametrised successor to the single-channel `top_pwm` block and keeps the same 8-bit-address / 32-bit-data register bus. It adds the following:
- N channels sharing one period counter;
- configurable counter width;
- double-buffered (shadow) period and duty registers, reloaded only at a period boundary;
- edge-aligned or center-aligned counting, per-channel output polarity;
- a maskable end-of-period interrupt.

## Interface
Parameters:
- `N_CH`, 4: number of PWM channels, 1..8.
- `CNT_W`, 16: counter, period and duty width, 2..16.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `addr` in 8: register byte address, word aligned.
- `wdata` in 32: write data.
- `wen` in 1: write strobe, one cycle per write.
- `ren` in 1: read strobe.
- `rdata` out 32: registered read data.
- `pwm_out` out N_CH: channel outputs, registered.
- `irq` out 1: level interrupt, `irq_en & period_done`.

## Operation
Register map. Unmapped reads return 0; unmapped writes are ignored.
- 0x00 GCTRL, R/W: bit0 `enable`, bit1 `mode` (0 edge, 1 center), bit2 `irq_en`.
- 0x04 PERIOD, R/W: staged period, bits [CNT_W-1:0].
- 0x08 STATUS:
  - bit0 `error_flag`, RO, live: 1 when any staged duty > staged period.
  - bit1 `period_done`, sticky, write-1-to-clear.
- 0x10+4·n CHn, R/W: bits [CNT_W-1:0] staged duty, bit31 `pol` (1 = invert output).

Reads return staged values, never active values.

Shadow reload:
- Active period, duty and pol load from the staged registers at each period boundary, and on every cycle while `enable`=0.
- A write coinciding with a boundary is staged; the active copy takes the old staged value, and the new value applies at the next boundary.

Counter:
- Edge mode: counts up 0..P-1, then wraps. The boundary is the cycle with cnt==P-1. Period is P cycles.
- Center mode: counts up 0..P-1, then down P-1..0. The boundary is down with cnt==0. Period is 2P cycles.
- A `mode` write takes effect at the next boundary, with the counter restarting at 0, up.
- P==0: counter held at 0, all outputs at idle level, no boundaries.

Compare and output:
- raw = (cnt < D).
- D ≥ P gives constant high (clamp); D==0 gives constant low.
- `pwm_out[n]` = raw ^ pol.

Enable:
- `enable`=0: counter held at 0, direction up; `pwm_out[n]` = pol (idle level).
- Rising `enable`: counting starts from 0 on the next cycle.

`period_done` set/clear:
- Set at each boundary.
- A W1C in the same cycle as a set leaves it set.

## Timing
- Reset values: all registers, counter, `rdata`, `pwm_out` and `irq` are 0.
- Reset mid-operation takes effect at the next edge, with no partial-period completion.
- Write latency: register updated at the edge where `wen`=1.
- Read latency: `rdata` is valid the edge after `ren` sampled high. It holds until the next read.
- Simultaneous `wen`/`ren`: the read returns the pre-write value.
- Output latency: `pwm_out` follows the counter by one register stage. Over any P consecutive cycles in edge mode, high count is exactly min(D,P).
- `irq`: registered, asserts the cycle after `period_done` sets.

## Structure
- Shared package `pwm_pkg` holds:
  - address constants ADDR_GCTRL, ADDR_PERIOD, ADDR_STATUS, ADDR_CH_BASE;
  - GCTRL/STATUS bit indices;
  - mode encodings MODE_EDGE/MODE_CENTER.
- Sub-module `pwm_channel`: one instance per channel. It holds the staged/active duty and pol, and does the compare, clamp and output register. It is driven by a shared counter, a reload strobe and the active period.
- Top level holds the bus decode, GCTRL/PERIOD/STATUS, the counter/direction logic and the read mux.

## Test plan
- Edge duty: PERIOD=100, CH0 duty=30, `enable`=1, mode=0 → 30 high / 70 low over 100 cycles; CH0 reads back 0x0000001E.
- Error flag: PERIOD=50, CH1 duty=60 → STATUS[0]=1; CH1 is constant high after reload; lowering duty to 40 clears STATUS[0].
- Shadow reload: running PERIOD=20, duty=5; write duty=12 mid-period → current period 5 high, next period 12 high, with no glitch.
- Center mode: PERIOD=10, duty=3, mode=1 → 6 high / 14 low per 20-cycle period; the high pulse is contiguous and wraps symmetrically around the counter-zero boundary.
- Interrupt: irq_en=1 → `irq` pulses high 1 cycle after each boundary and stays high. W1C of STATUS[1] clears it; W1C on a boundary cycle leaves it set.
- Polarity/reset: CH2 pol=1, duty=0 → constant high. `reset` asserted mid-period → next edge all outputs, registers and `rdata` are 0.
